// File: rtl/stop_ctrl_multi_if.sv
// Bus between the capture write-address logic / host and the stop controller.
// The hit-count port exists only when STOP_TRIG_COUNT_EN is defined.
interface stop_ctrl_multi_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int NUM_TRIG      = 4
`ifdef STOP_TRIG_COUNT_EN
  , parameter int TRIG_CNT_WIDTH = 8
`endif
);
  logic [ADDR_WIDTH-1:0]    waddr;
  logic                     primed;
  logic [NUM_TRIG-1:0]      i_trigger;
  logic [NUM_TRIG-1:0]      i_trig_mask;
  logic [NUM_TRIG-1:0]      i_trig_edge;
  logic                     i_trig_all;
  logic [HOLDOFF_WIDTH-1:0] i_holdoff;
  logic                     i_rearm;
`ifdef STOP_TRIG_COUNT_EN
  logic [TRIG_CNT_WIDTH-1:0] i_trig_count;
`endif
  logic                     stopped;
  logic                     triggered;
  logic [ADDR_WIDTH-1:0]    trigger_addr;
  logic [1:0]               o_state;

  modport master (
    output waddr, primed, i_trigger, i_trig_mask, i_trig_edge, i_trig_all,
           i_holdoff, i_rearm,
`ifdef STOP_TRIG_COUNT_EN
           i_trig_count,
`endif
    input  stopped, triggered, trigger_addr, o_state
  );

  modport slave (
    input  waddr, primed, i_trigger, i_trig_mask, i_trig_edge, i_trig_all,
           i_holdoff, i_rearm,
`ifdef STOP_TRIG_COUNT_EN
           i_trig_count,
`endif
    output stopped, triggered, trigger_addr, o_state
  );
endinterface

// File: rtl/stop_ctrl_multi.sv
// Capture-stop controller: multi-channel trigger qualify, holdoff, then freeze writes.
// Optional macro STOP_TRIG_COUNT_EN: require N qualified hits before triggering.
module stop_ctrl_lane (
  input  logic i_trig,
  input  logic i_prev,
  input  logic i_edge,
  input  logic i_mask,
  output logic o_hit
);
  assign o_hit = i_mask & (i_edge ? (i_trig & ~i_prev) : i_trig);
endmodule

module stop_ctrl_multi #(
  parameter int ADDR_WIDTH    = 10,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int NUM_TRIG      = 4
`ifdef STOP_TRIG_COUNT_EN
  , parameter int TRIG_CNT_WIDTH = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  stop_ctrl_multi_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [NUM_TRIG-1:0]      r_prev, w_hit;
  logic [HOLDOFF_WIDTH-1:0] r_cnt, w_cnt_nxt, r_hold, w_hold_nxt;
  logic [ADDR_WIDTH-1:0]    r_taddr, w_taddr_nxt;
  logic                     r_stopped, w_stopped_nxt;
  logic                     r_trig, w_trig_nxt;
  logic                     w_any, w_all, w_qual, w_fire;

  genvar g;
  generate
    for (g = 0; g < NUM_TRIG; g++) begin : g_lane
      stop_ctrl_lane u_lane (
        .i_trig (bus.i_trigger[g]),
        .i_prev (r_prev[g]),
        .i_edge (bus.i_trig_edge[g]),
        .i_mask (bus.i_trig_mask[g]),
        .o_hit  (w_hit[g])
      );
    end
  endgenerate

  // w_hit is already masked; AND mode needs every enabled lane and a non-empty mask.
  assign w_any  = |w_hit;
  assign w_all  = (|bus.i_trig_mask) && (w_hit == bus.i_trig_mask);
  assign w_qual = bus.i_trig_all ? w_all : w_any;

`ifdef STOP_TRIG_COUNT_EN
  logic [TRIG_CNT_WIDTH-1:0] r_hcnt, w_hcnt_nxt, w_hcnt_inc, w_target;

  assign w_hcnt_inc = r_hcnt + 1'b1;
  assign w_target   = (bus.i_trig_count == '0) ? TRIG_CNT_WIDTH'(1) : bus.i_trig_count;
  assign w_fire     = w_qual && (w_hcnt_inc == w_target);

  always_comb begin
    w_hcnt_nxt = r_hcnt;
    if (bus.i_rearm)
      w_hcnt_nxt = '0;
    else if (r_state == S_IDLE && bus.primed)
      w_hcnt_nxt = '0;
    else if (r_state == S_WAIT && bus.primed && w_qual)
      w_hcnt_nxt = w_hcnt_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_hcnt <= '0;
    else        r_hcnt <= w_hcnt_nxt;
  end
`else
  assign w_fire = w_qual;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_taddr_nxt   = r_taddr;
    w_stopped_nxt = r_stopped;
    w_trig_nxt    = r_trig;
    if (bus.i_rearm) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_stopped_nxt = 1'b0;
      w_trig_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.primed) w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (!bus.primed) begin
            w_state_nxt = S_IDLE;
          end else if (w_fire) begin
            w_state_nxt = S_HOLD;
            w_trig_nxt  = 1'b1;
            w_taddr_nxt = bus.waddr;
            w_cnt_nxt   = '0;
            w_hold_nxt  = bus.i_holdoff;
          end
        end
        // Equality against the latched value; counter never passes it, so no wrap.
        S_HOLD: begin
          if (r_cnt == r_hold) begin
            w_state_nxt   = S_STOP;
            w_stopped_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_STOP: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_prev    <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_taddr   <= '0;
      r_stopped <= 1'b0;
      r_trig    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= bus.i_trigger;
      r_cnt     <= w_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_taddr   <= w_taddr_nxt;
      r_stopped <= w_stopped_nxt;
      r_trig    <= w_trig_nxt;
    end
  end

  assign bus.stopped      = r_stopped;
  assign bus.triggered    = r_trig;
  assign bus.trigger_addr = r_taddr;
  assign bus.o_state      = r_state;
endmodule

// File: tb/tb_stop_ctrl_multi.sv
// Directed + randomized bench for stop_ctrl_multi against a cycle-level reference model.
module tb_stop_ctrl_multi;
  localparam int AW  = 10;
  localparam int HW  = 16;
  localparam int NT  = 4;
  localparam int TCW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef STOP_TRIG_COUNT_EN
  stop_ctrl_multi_if #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW), .NUM_TRIG(NT), .TRIG_CNT_WIDTH(TCW)) bus();
  stop_ctrl_multi #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW), .NUM_TRIG(NT), .TRIG_CNT_WIDTH(TCW))
    dut (.clk(clk), .reset(reset), .bus(bus));
`else
  stop_ctrl_multi_if #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW), .NUM_TRIG(NT)) bus();
  stop_ctrl_multi #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW), .NUM_TRIG(NT))
    dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state numbers as the host sees them (0 idle .. 3 stopped).
  int          m_state;
  logic [NT-1:0] m_prev;
  int unsigned m_cnt, m_H;
  logic [AW-1:0] m_taddr;
  bit          m_trig, m_stop;
  int unsigned m_hits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    check({tag, ".state"}, 32'(bus.o_state), 32'(m_state));
    check({tag, ".trig"},  32'(bus.triggered), 32'(m_trig));
    check({tag, ".stop"},  32'(bus.stopped), 32'(m_stop));
    check({tag, ".taddr"}, 32'(bus.trigger_addr), 32'(m_taddr));
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = '0; m_cnt = 0; m_H = 0;
    m_taddr = '0; m_trig = 0; m_stop = 0; m_hits = 0;
  endtask

  // Count enabled channels and how many of them see their event this cycle.
  function automatic bit qualified();
    int n_en, n_hit;
    bit h;
    n_en = 0; n_hit = 0;
    for (int i = 0; i < NT; i++) begin
      if (bus.i_trig_mask[i]) begin
        n_en++;
        h = bus.i_trig_edge[i] ? (bus.i_trigger[i] && !m_prev[i]) : bus.i_trigger[i];
        if (h) n_hit++;
      end
    end
    if (n_en == 0) return 1'b0;
    return bus.i_trig_all ? (n_hit == n_en) : (n_hit > 0);
  endfunction

  task automatic model_clk();
    bit q, fire;
    int unsigned need;
    if (!reset) begin
      model_reset();
      return;
    end
    q = qualified();
    if (bus.i_rearm) begin
      m_state = 0; m_trig = 0; m_stop = 0; m_cnt = 0; m_hits = 0;
    end else if (m_state == 0) begin
      if (bus.primed) begin m_state = 1; m_hits = 0; end
    end else if (m_state == 1) begin
      if (!bus.primed) m_state = 0;
      else if (q) begin
`ifdef STOP_TRIG_COUNT_EN
        need   = (bus.i_trig_count == 0) ? 1 : 32'(bus.i_trig_count);
        m_hits = (m_hits + 1) % (1 << TCW);
        fire   = (m_hits == need);
`else
        need = 1;
        fire = (need == 1);
`endif
        if (fire) begin
          m_state = 2; m_trig = 1; m_taddr = bus.waddr; m_cnt = 0; m_H = 32'(bus.i_holdoff);
        end
      end
    end else if (m_state == 2) begin
      if (m_cnt == m_H) begin m_state = 3; m_stop = 1; end
      else m_cnt++;
    end
    m_prev = bus.i_trigger;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clk();
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic rearm_pulse(input string tag);
    bus.i_rearm = 1'b1;
    step(tag);
    bus.i_rearm = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.waddr = '0; bus.primed = 1'b0; bus.i_trigger = '0; bus.i_trig_mask = '0;
    bus.i_trig_edge = '0; bus.i_trig_all = 1'b0; bus.i_holdoff = '0; bus.i_rearm = 1'b0;
`ifdef STOP_TRIG_COUNT_EN
    bus.i_trig_count = '0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("reset");
    reset = 1'b1;

    // OR mode, level ch1, holdoff 5
    bus.i_trig_mask = 4'b0010; bus.i_holdoff = 16'd5; bus.primed = 1'b1;
    step("or_arm");
    bus.i_trigger = 4'b0010; bus.waddr = 10'h123;
    step("or_hit");
    check("or_trig", 32'(bus.triggered), 32'd1);
    check("or_taddr", 32'(bus.trigger_addr), 32'h123);
    bus.i_trigger = '0; bus.i_holdoff = 16'd9; bus.waddr = 10'h055;
    for (int i = 0; i < 5; i++) step("or_hold");
    check("or_not_yet", 32'(bus.stopped), 32'd0);
    step("or_stop");
    check("or_stopped", 32'(bus.stopped), 32'd1);
    repeat (3) step("or_frozen");

    // rearm from STOPPED keeps trigger_addr
    rearm_pulse("rearm_stop");
    check("rearm_stop_s", 32'(bus.stopped), 32'd0);
    check("rearm_taddr", 32'(bus.trigger_addr), 32'h123);

    // async reset mid-holdoff
    bus.i_holdoff = 16'd100;
    step("ar_arm");
    bus.i_trigger = 4'b0010; bus.waddr = 10'h2AA;
    step("ar_hit");
    bus.i_trigger = '0;
    repeat (40) step("ar_hold");
    reset = 1'b0;
    #1;
    model_reset();
    check("ar_state", 32'(bus.o_state), 32'd0);
    check("ar_trig", 32'(bus.triggered), 32'd0);
    check("ar_stop", 32'(bus.stopped), 32'd0);
    check("ar_taddr", 32'(bus.trigger_addr), 32'd0);
    step("ar_held");
    @(negedge clk);
    reset = 1'b1;

    // AND mode: ch2 level held, ch0 rising edge
    bus.i_trig_all = 1'b1; bus.i_trig_mask = 4'b0101; bus.i_trig_edge = 4'b0001;
    bus.i_holdoff = 16'd2; bus.i_trigger = 4'b0100;
    step("and_arm");
    step("and_wait");
    bus.i_trigger = 4'b0101; bus.waddr = 10'h0F0;
    step("and_hit");
    check("and_trig", 32'(bus.triggered), 32'd1);
    rearm_pulse("and_rearm");
    repeat (6) step("and_nohit");
    check("and_single", 32'(bus.triggered), 32'd0);
    bus.i_trig_mask = '0; bus.i_trig_edge = '0; bus.i_trigger = 4'b1111;
    repeat (3) step("mask0_and");
    bus.i_trig_all = 1'b0;
    repeat (3) step("mask0_or");
    check("mask0", 32'(bus.triggered), 32'd0);

    // H=0: stopped one cycle after triggered
    bus.i_trig_mask = 4'b0001; bus.i_trigger = '0; bus.i_holdoff = '0;
    step("h0_idle");
    bus.i_trigger = 4'b0001; bus.waddr = 10'h3FF;
    step("h0_hit");
    check("h0_trig", 32'(bus.triggered), 32'd1);
    check("h0_nostop", 32'(bus.stopped), 32'd0);
    step("h0_next");
    check("h0_stop", 32'(bus.stopped), 32'd1);

    // H=max: no wrap
    rearm_pulse("hmax_rearm");
    bus.i_trigger = '0; bus.i_holdoff = 16'hFFFF;
    step("hmax_arm");
    bus.i_trigger = 4'b0001; bus.waddr = 10'h111;
    step("hmax_hit");
    bus.i_trigger = '0;
    for (int i = 0; i < 65535; i++) step("hmax_hold");
    check("hmax_not_yet", 32'(bus.stopped), 32'd0);
    step("hmax_stop");
    check("hmax_stopped", 32'(bus.stopped), 32'd1);

    // primed drop in WAIT, rearm beats a hit
    rearm_pulse("pd_rearm");
    step("pd_wait");
    bus.primed = 1'b0;
    step("pd_drop");
    check("pd_state", 32'(bus.o_state), 32'd0);
    bus.primed = 1'b1;
    step("rh_wait");
    bus.i_trigger = 4'b0001; bus.i_rearm = 1'b1;
    step("rh_both");
    bus.i_rearm = 1'b0; bus.i_trigger = '0;
    check("rh_state", 32'(bus.o_state), 32'd0);
    check("rh_trig", 32'(bus.triggered), 32'd0);

`ifdef STOP_TRIG_COUNT_EN
    // third qualified hit triggers
    bus.i_trig_count = 8'd3; bus.i_trig_edge = 4'b0001; bus.i_holdoff = 16'd1;
    step("tc_wait");
    for (int i = 0; i < 3; i++) begin
      bus.i_trigger = 4'b0001; bus.waddr = AW'(10'h200 + i);
      step("tc_hit");
      bus.i_trigger = '0;
      step("tc_gap");
    end
    check("tc_taddr", 32'(bus.trigger_addr), 32'h202);
    rearm_pulse("tc_rearm");
    bus.i_trig_count = '0;
    step("tc0_wait");
    bus.i_trigger = 4'b0001; bus.waddr = 10'h077;
    step("tc0_hit");
    check("tc0_trig", 32'(bus.triggered), 32'd1);
    bus.i_trigger = '0;
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        bus.i_trig_mask = NT'($urandom);
        bus.i_trig_edge = NT'($urandom);
        bus.i_trig_all  = 1'($urandom);
`ifdef STOP_TRIG_COUNT_EN
        bus.i_trig_count = TCW'($urandom_range(0, 3));
`endif
      end
      bus.primed    = ($urandom_range(0, 9) != 0);
      bus.i_rearm   = ($urandom_range(0, 39) == 0);
      bus.i_trigger = NT'($urandom);
      bus.i_holdoff = HW'($urandom_range(0, 6));
      bus.waddr     = AW'($urandom);
      step("rand");
    end
    bus.i_rearm = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
